// File: rtl/data_format_adapter_pack_if.sv
// data_format_adapter_pack_if: 8-bit symbol sink side plus packed multi-symbol source side
interface data_format_adapter_pack_if #(
    parameter int SYMBOL_WIDTH     = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int EMPTY_WIDTH      = 2
);
    logic                                 in_ready;
    logic                                 in_valid;
    logic [SYMBOL_WIDTH-1:0]              in_data;
    logic                                 in_startofpacket;
    logic                                 in_endofpacket;
    logic                                 out_ready;
    logic                                 out_valid;
    logic [SYMBOL_WIDTH*SYMBOLS_PER_BEAT-1:0] out_data;
    logic                                 out_startofpacket;
    logic                                 out_endofpacket;
    logic [EMPTY_WIDTH-1:0]               out_empty;

    modport slave (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
    );

    modport master (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
    );
endinterface

// File: rtl/data_format_adapter_pack.sv
// data_format_adapter_pack: packs one-symbol beats into SYMBOLS_PER_BEAT-symbol beats with empty count
module data_format_adapter_pack #(
    parameter int SYMBOL_WIDTH     = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int EMPTY_WIDTH      = 2
) (
    input logic                       clk,
    input logic                       reset_n,
    data_format_adapter_pack_if.slave bus
);
    localparam int SW = SYMBOL_WIDTH;
    localparam int N  = SYMBOLS_PER_BEAT;
    localparam int CW = $clog2(N);

    logic [CW-1:0]          cnt_q, cnt_d, eff_cnt;
    logic [(N-1)*SW-1:0]    acc_q, acc_d;
    logic                   sop_pend_q, sop_pend_d;
    logic                   out_valid_q, out_valid_d;
    logic [N*SW-1:0]        out_data_q, out_data_d, lanes;
    logic                   out_sop_q, out_sop_d;
    logic                   out_eop_q, out_eop_d;
    logic [EMPTY_WIDTH-1:0] out_empty_q, out_empty_d;
    logic                   in_ready, accept, complete;

    assign bus.in_ready          = in_ready;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_data_q;
    assign bus.out_startofpacket = out_sop_q;
    assign bus.out_endofpacket   = out_eop_q;
    assign bus.out_empty         = out_empty_q;

    // Accept a symbol whenever the holding register is free or draining; a mid-beat sop restarts at lane 0
    always_comb begin
        in_ready    = !out_valid_q || bus.out_ready;
        accept      = bus.in_valid && in_ready;
        eff_cnt     = bus.in_startofpacket ? '0 : cnt_q;
        complete    = eff_cnt == CW'(N-1) || bus.in_endofpacket;
        lanes       = {acc_q, {SW{1'b0}}};
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sop_pend_d  = sop_pend_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        if (accept && complete) begin
            for (int i = 0; i < N; i++)
                out_data_d[(N-1-i)*SW +: SW] = CW'(i) < eff_cnt ? lanes[(N-1-i)*SW +: SW] :
                                               CW'(i) == eff_cnt ? bus.in_data : '0;
            out_empty_d = EMPTY_WIDTH'(N - 1 - int'(eff_cnt));
            out_sop_d   = eff_cnt == '0 ? bus.in_startofpacket : sop_pend_q;
            out_eop_d   = bus.in_endofpacket;
            out_valid_d = 1'b1;
            cnt_d       = '0;
        end else if (accept) begin
            for (int i = 0; i < N - 1; i++)
                if (CW'(i) == eff_cnt) acc_d[(N-2-i)*SW +: SW] = bus.in_data;
            cnt_d = eff_cnt + CW'(1);
            if (eff_cnt == '0) sop_pend_d = bus.in_startofpacket;
        end
    end

    // State and output holding register, cleared asynchronously so a reset drops partial and pending beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            sop_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sop_pend_q  <= sop_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
        end
    end
endmodule

// File: tb/tb_data_format_adapter_pack.sv
// tb_data_format_adapter_pack: directed and random stimulus against a queue-based packing model
module tb_data_format_adapter_pack;
    typedef struct packed {
        logic [23:0] d;
        logic        s;
        logic        e;
        logic [1:0]  m;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   ready_mode = 0;
    logic [8:0] part[$];
    beat_t exp_q[$];
    beat_t got_q[$];

    always #5 clk = ~clk;

    data_format_adapter_pack_if bus ();
    data_format_adapter_pack dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic beat_t mk_beat(input logic e);
        beat_t b;
        b = '0;
        foreach (part[i]) b.d[23-8*i -: 8] = part[i][7:0];
        b.s = part[0][8];
        b.e = e;
        b.m = 2'(3 - part.size());
        return b;
    endfunction

    function automatic beat_t dut_beat();
        return {bus.out_data, bus.out_startofpacket, bus.out_endofpacket, bus.out_empty};
    endfunction

    // Reference model: symbols gather in a queue; a beat is due once three are held or eop arrives
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            part.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(dut_beat());
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                if (bus.in_startofpacket) part.delete();
                part.push_back({bus.in_startofpacket, bus.in_data});
                if (part.size() == 3 || bus.in_endofpacket) begin
                    exp_q.push_back(mk_beat(bus.in_endofpacket));
                    part.delete();
                end
            end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the clock edge
    always @(posedge clk) begin
        #3;
        if (reset_n) begin
            chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0 && bus.out_valid) chk("beat", 64'(dut_beat()), 64'(exp_q[0]));
            chk("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
        end
    end

    task automatic set_ready();
        bus.out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            set_ready();
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_startofpacket = s;
        bus.in_endofpacket = e;
        while (1) begin
            set_ready();
            #1;
            if (bus.in_ready) break;
            if (++n > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready got 0 for 200 cycles, required 1 (symbol %0h)", d);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_beat(input string name, input int idx, input beat_t req);
        if (idx >= got_q.size()) begin
            tests++;
            fails++;
            $display("FAIL %s: got %0d beats, required beat %0d", name, got_q.size(), idx);
        end else chk(name, 64'(got_q[idx]), 64'(req));
    endtask

    initial begin
        int g;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_startofpacket = 1'b0;
        bus.in_endofpacket = 1'b0;
        bus.out_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_flags", 64'({bus.out_startofpacket, bus.out_endofpacket, bus.out_empty}), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        g = got_q.size();
        send(8'h11, 1, 0); send(8'h22, 0, 0); send(8'h33, 0, 0);
        send(8'h44, 0, 0); send(8'h55, 0, 0); send(8'h66, 0, 1);
        idle(4);
        chk("t1_count", 64'(got_q.size() - g), 64'(2));
        chk_beat("t1_b0", g, beat_t'{24'h112233, 1'b1, 1'b0, 2'd0});
        chk_beat("t1_b1", g + 1, beat_t'{24'h445566, 1'b0, 1'b1, 2'd0});

        g = got_q.size();
        send(8'hA1, 1, 0); send(8'hA2, 0, 0); send(8'hA3, 0, 0); send(8'hA4, 0, 1);
        send(8'hB1, 1, 0); send(8'hB2, 0, 1);
        idle(4);
        chk_beat("t2_a0", g, beat_t'{24'hA1A2A3, 1'b1, 1'b0, 2'd0});
        chk_beat("t2_a1", g + 1, beat_t'{24'hA40000, 1'b0, 1'b1, 2'd2});
        chk_beat("t2_b0", g + 2, beat_t'{24'hB1B200, 1'b1, 1'b1, 2'd1});

        g = got_q.size();
        send(8'h5A, 1, 1);
        idle(3);
        chk_beat("t3_single", g, beat_t'{24'h5A0000, 1'b1, 1'b1, 2'd2});

        g = got_q.size();
        ready_mode = 2;
        fork
            begin
                send(8'h11, 1, 0); send(8'h22, 0, 0); send(8'h33, 0, 0);
                send(8'h44, 0, 0); send(8'h55, 0, 0); send(8'h66, 0, 1);
            end
            begin
                repeat (10) @(negedge clk);
                #2;
                chk("t4_stall_in_ready", 64'(bus.in_ready), 64'(0));
                chk("t4_hold_valid", 64'(bus.out_valid), 64'(1));
                chk("t4_hold_data", 64'(bus.out_data), 64'(24'h112233));
                ready_mode = 0;
            end
        join
        idle(4);
        chk("t4_count", 64'(got_q.size() - g), 64'(2));
        chk_beat("t4_b0", g, beat_t'{24'h112233, 1'b1, 1'b0, 2'd0});
        chk_beat("t4_b1", g + 1, beat_t'{24'h445566, 1'b0, 1'b1, 2'd0});

        g = got_q.size();
        send(8'hC1, 1, 0); send(8'hC2, 0, 0);
        send(8'hD1, 1, 0); send(8'hD2, 0, 0); send(8'hD3, 0, 1);
        idle(4);
        chk("t5_count", 64'(got_q.size() - g), 64'(1));
        chk_beat("t5_d", g, beat_t'{24'hD1D2D3, 1'b1, 1'b1, 2'd0});

        g = got_q.size();
        ready_mode = 2;
        send(8'h71, 1, 0); send(8'h72, 0, 0); send(8'h73, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("t6_rst_data", 64'(bus.out_data), 64'(0));
        chk("t6_rst_flags", 64'({bus.out_startofpacket, bus.out_endofpacket, bus.out_empty}), 64'(0));
        chk("t6_rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        reset_n = 1'b1;
        ready_mode = 0;
        send(8'hF1, 1, 0); send(8'hF2, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst2_valid", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        send(8'hE1, 1, 0); send(8'hE2, 0, 0); send(8'hE3, 0, 1);
        idle(4);
        chk("t6_count", 64'(got_q.size() - g), 64'(1));
        chk_beat("t6_e", g, beat_t'{24'hE1E2E3, 1'b1, 1'b1, 2'd0});

        ready_mode = 1;
        for (int k = 0; k < 400; k++) begin
            send(8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        ready_mode = 0;
        idle(6);
        chk("rand_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_format_adapter_pack.md
# data_format_adapter_pack

Avalon-ST packing adapter that converts an 8-bit, one-symbol-per-beat packet stream into a 24-bit, three-symbol-per-beat stream with an `out_empty` field. It sits on the input side of the 24-bit video/data path and undoes the narrowing done elsewhere. Partial final beats are flagged through `out_empty` so that downstream empty-aware sinks see exact packet lengths.

## Interface
- SYMBOL_WIDTH, 8, bits per symbol.
- SYMBOLS_PER_BEAT, 3, symbols packed per output beat. Widths below are for the defaults.
- EMPTY_WIDTH, 2, width of `out_empty`, which must be at least clog2(SYMBOLS_PER_BEAT).
- clk  input  1  single clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_ready  output  1  sink ready.
- in_valid  input  1  symbol valid.
- in_data  input  8  one symbol.
- in_startofpacket  input  1  first symbol of packet.
- in_endofpacket  input  1  last symbol of packet.
- out_ready  input  1  downstream ready.
- out_valid  output  1  packed beat valid.
- out_data  output  24  packed beat; first symbol is in [23:16], second in [15:8], third in [7:0].
- out_startofpacket  output  1  beat holds the packet's first symbol.
- out_endofpacket  output  1  beat holds the packet's last symbol.
- out_empty  output  2  number of unused low-order symbol lanes; valid only when out_endofpacket is high.

## Operation
**State**
- Lane counter `cnt` ranges over 0..SYMBOLS_PER_BEAT-1.
- Accumulation registers hold lanes 0..N-2.
- `sop_pend` flag records whether the beat being accumulated started a packet.
- One output holding register carries data, sop, eop and empty.

**Ready rule**
- in_ready = !out_valid || out_ready. This is combinational from out_ready and the output register state.

**Accept (in_valid && in_ready)**
- If in_startofpacket and cnt != 0 (a new packet begins mid-beat): discard the partial accumulation and treat the symbol as lane 0 of a new beat.
- Completing symbol (effective cnt == N-1, or in_endofpacket):
  - Load the output register with the accumulated lanes plus this symbol in lane cnt.
  - Lanes above cnt are zero.
  - out_empty = N-1-cnt.
  - out_startofpacket = (cnt == 0 ? in_startofpacket : sop_pend).
  - out_endofpacket = in_endofpacket.
  - Set out_valid; set cnt to 0.
- Otherwise:
  - Store the symbol in lane cnt and increment cnt.
  - If cnt was 0, set sop_pend = in_startofpacket.

**Output handshake**
- out_valid, out_data, out_startofpacket, out_endofpacket and out_empty stay stable while out_valid && !out_ready.
- When out_valid && out_ready and no new beat completes in the same cycle, clear out_valid.
- If a beat completes in the same cycle the current one drains, load the new beat with no bubble.

**Stream assumptions**
- Symbols outside a packet (before any sop) are packed normally. No framing checks are made beyond the mid-beat sop rule.

## Timing
**Reset values** (reset_n low, asynchronous)
- out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_empty=0.
- cnt=0, sop_pend=0, accumulation registers=0.
- in_ready is 1 during and after reset, because out_valid=0.

**Latency and throughput**
- Latency is 1 cycle: the completing symbol is accepted at edge k, and out_valid is high after edge k.
- Throughput is 1 symbol per cycle sustained, giving one output beat every 3 cycles for full beats.
- Input never stalls while out_ready is held high.

**Backpressure**
- With out_valid=1 and out_ready=0, in_ready=0. No symbols are accepted, including non-completing ones, so no data is lost.

**Reset mid-operation**
- A partial beat and any pending output beat are dropped with no output.
- Operation restarts from cnt=0 on the first edge after reset_n rises.

**Simultaneous events**
- Sop and eop on the same symbol produce a single beat with sop=1, eop=1, empty=2.
- An eop symbol at cnt=2 produces empty=0.

## Test plan
1. **Full packet:** send a 6-symbol packet 0x11..0x66 (sop on 0x11, eop on 0x66) with out_ready=1.
   - Beat 1: 0x112233, sop=1, eop=0.
   - Beat 2: 0x445566, eop=1, empty=0.
   - Each beat appears 1 cycle after its third symbol.
2. **Short final beats:** send 4-symbol packet A1,A2,A3,A4, then 2-symbol packet B1,B2.
   - Packet A: 0xA1A2A3 (sop), then 0xA40000 (eop, empty=2).
   - Packet B: 0xB1B200 (sop, eop, empty=1).
3. **Single-symbol packet:** send 0x5A with sop and eop together.
   - One beat: 0x5A0000, sop=1, eop=1, empty=2.
4. **Backpressure:** hold out_ready=0 while a 6-symbol packet streams in.
   - in_ready drops after the first beat forms.
   - out_data holds 0x112233 stable.
   - After out_ready rises, all 6 symbols arrive intact and in order with no duplicates.
5. **Mid-beat sop:** send sop C1, then C2, then sop D1, D2, D3 with eop on D3.
   - C1 and C2 are discarded.
   - Output is 0xD1D2D3 with sop=1, eop=1, empty=0.
6. **Reset mid-operation:** assert reset_n low after 2 symbols of a beat and with an undrained beat pending.
   - All outputs go to 0 immediately (asynchronous).
   - After release, a fresh 3-symbol packet packs from lane 0 correctly.
